// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: central sequencer for the 16x16 flappy-bird playfield.
// Owns the game FSM (IDLE/READY/PLAY/PAUSE/OVER). Generates the single-cycle
// gravity, pipe-shift and pipe-spawn enables. Keeps the 0..999 score and
// shortens the pipe period as the score climbs.
// Optional feature: define GOD_MODE_EN to add a god_mode input. While god_mode
// is high, collisions are ignored in PLAY.
module game_tick_scheduler #(
  parameter int GRAV_DIV       = 768,
  parameter int PIPE_DIV_START = 1536,
  parameter int PIPE_DIV_MIN   = 512,
  parameter int SPEEDUP_STEP   = 128,
  parameter int SCORE_STEP     = 4,
  parameter int SPAWN_GAP      = 5,
  parameter int COUNTDOWN_CYC  = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  input  logic       gate_pass,
`ifdef GOD_MODE_EN
  input  logic       god_mode,
`endif
  output logic       gravity_tick,
  output logic       pipe_tick,
  output logic       spawn_tick,
  output logic       field_clear,
  output logic       game_over,
  output logic [2:0] state,
  output logic [9:0] score
);

  localparam int GW  = $clog2(GRAV_DIV);
  localparam int PW  = $clog2(PIPE_DIV_START + 1);
  localparam int SW  = $clog2(SPAWN_GAP + 1);
  localparam int STW = $clog2(SCORE_STEP + 1);
  localparam int CW  = $clog2(COUNTDOWN_CYC + 1);

  localparam logic [GW-1:0]  GRAV_LAST   = GW'(GRAV_DIV - 1);
  localparam logic [SW-1:0]  SPAWN_LAST  = SW'(SPAWN_GAP - 1);
  localparam logic [STW-1:0] STEP_LAST   = STW'(SCORE_STEP - 1);
  localparam logic [CW-1:0]  CD_LAST     = CW'(COUNTDOWN_CYC - 1);
  localparam logic [31:0]    SPEED_FLOOR = 32'(PIPE_DIV_MIN + SPEEDUP_STEP);
  localparam logic [9:0]     SCORE_MAX   = 10'd999;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           cur_state;
  logic [GW-1:0]    grav_cnt;
  logic [PW-1:0]    pipe_cnt;
  logic [PW-1:0]    pipe_period;
  logic [SW-1:0]    spawn_cnt;
  logic [STW-1:0]   step_cnt;
  logic [CW-1:0]    countdown;

  logic             hit;
  logic             load_ready;
  logic             play_run;
  logic             score_inc;
  logic             grav_wrap;
  logic             pipe_wrap;
  logic             spawn_wrap;
  logic [31:0]      period_wide;
  logic [PW-1:0]    next_period;

`ifdef GOD_MODE_EN
  assign hit = collision & ~god_mode;
`else
  assign hit = collision;
`endif

  assign state       = cur_state;
  assign load_ready  = start && (cur_state == S_IDLE || cur_state == S_OVER);
  assign play_run    = (cur_state == S_PLAY) && !hit && !pause;
  assign score_inc   = (cur_state == S_PLAY) && gate_pass && !hit && (score != SCORE_MAX);
  assign grav_wrap   = (grav_cnt == GRAV_LAST);
  assign pipe_wrap   = (pipe_cnt >= (pipe_period - PW'(1)));
  assign spawn_wrap  = (spawn_cnt == SPAWN_LAST);
  assign period_wide = 32'(pipe_period);
  assign next_period = (period_wide >= SPEED_FLOOR) ? (pipe_period - PW'(SPEEDUP_STEP))
                                                    : PW'(PIPE_DIV_MIN);

  // Game FSM with registered field_clear/game_over flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= S_IDLE;
      field_clear <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (start) cur_state <= S_READY;
        end
        S_READY: begin
          if (countdown == '0) begin
            cur_state   <= S_PLAY;
            field_clear <= 1'b0;
          end
        end
        S_PLAY: begin
          if (hit) begin
            cur_state <= S_OVER;
            game_over <= 1'b1;
          end else if (pause) begin
            cur_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!pause) cur_state <= S_PLAY;
        end
        S_OVER: begin
          if (start) begin
            cur_state   <= S_READY;
            field_clear <= 1'b1;
            game_over   <= 1'b0;
          end
        end
        default: begin
          cur_state   <= S_IDLE;
          field_clear <= 1'b1;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

  // READY countdown, loaded on every entry into READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      countdown <= '0;
    end else if (load_ready) begin
      countdown <= CD_LAST;
    end else if (cur_state == S_READY && countdown != '0) begin
      countdown <= countdown - CW'(1);
    end
  end

  // Tick dividers: advance only while PLAY continues, so pause/over freeze the phase.
  always_ff @(posedge clk) begin
    if (reset || load_ready) begin
      grav_cnt     <= '0;
      pipe_cnt     <= '0;
      spawn_cnt    <= '0;
      gravity_tick <= 1'b0;
      pipe_tick    <= 1'b0;
      spawn_tick   <= 1'b0;
    end else begin
      gravity_tick <= 1'b0;
      pipe_tick    <= 1'b0;
      spawn_tick   <= 1'b0;
      if (play_run) begin
        if (grav_wrap) begin
          grav_cnt     <= '0;
          gravity_tick <= 1'b1;
        end else begin
          grav_cnt <= grav_cnt + GW'(1);
        end
        if (pipe_wrap) begin
          pipe_cnt  <= '0;
          pipe_tick <= 1'b1;
          if (spawn_wrap) begin
            spawn_cnt  <= '0;
            spawn_tick <= 1'b1;
          end else begin
            spawn_cnt <= spawn_cnt + SW'(1);
          end
        end else begin
          pipe_cnt <= pipe_cnt + PW'(1);
        end
      end
    end
  end

  // Score and speed ramp; step_cnt tracks the score modulo SCORE_STEP.
  always_ff @(posedge clk) begin
    if (reset || load_ready) begin
      score       <= '0;
      step_cnt    <= '0;
      pipe_period <= PW'(PIPE_DIV_START);
    end else if (score_inc) begin
      score <= score + 10'd1;
      if (step_cnt == STEP_LAST) begin
        step_cnt    <= '0;
        pipe_period <= next_period;
      end else begin
        step_cnt <= step_cnt + STW'(1);
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed bench for game_tick_scheduler.
// Tick events go through per-tick scoreboard queues of expected cycle numbers.
// An independent monitor pops each queue and compares.
// When GOD_MODE_EN is defined, the god_mode port is also exercised.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       collision = 1'b0;
  logic       gate_pass = 1'b0;
`ifdef GOD_MODE_EN
  logic       god_mode = 1'b0;
`endif
  logic       gravity_tick;
  logic       pipe_tick;
  logic       spawn_tick;
  logic       field_clear;
  logic       game_over;
  logic [2:0] state;
  logic [9:0] score;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int gq[$];
  int pq[$];
  int sq[$];

  int p0, b, c3, c4, p1, end_edge;

  game_tick_scheduler #(
    .GRAV_DIV(4), .PIPE_DIV_START(8), .PIPE_DIV_MIN(4), .SPEEDUP_STEP(2),
    .SCORE_STEP(2), .SPAWN_GAP(3), .COUNTDOWN_CYC(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .collision(collision),
    .gate_pass(gate_pass),
`ifdef GOD_MODE_EN
    .god_mode(god_mode),
`endif
    .gravity_tick(gravity_tick),
    .pipe_tick(pipe_tick),
    .spawn_tick(spawn_tick),
    .field_clear(field_clear),
    .game_over(game_over),
    .state(state),
    .score(score)
  );

  // 10 time-unit clock; cyc counts rising edges.
  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp tick events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic g,
                               input int n);
    start = s;
    pause = p;
    collision = c;
    gate_pass = g;
    repeat (n) @(negedge clk);
  endtask

  // Expected ticks whose cycle already passed without being seen are misses.
  task automatic flushMissed();
    while (gq.size() > 0 && gq[0] < cyc) checkOutput("gravity_tick missing at cycle", -1, gq.pop_front());
    while (pq.size() > 0 && pq[0] < cyc) checkOutput("pipe_tick missing at cycle", -1, pq.pop_front());
    while (sq.size() > 0 && sq[0] < cyc) checkOutput("spawn_tick missing at cycle", -1, sq.pop_front());
  endtask

  // Monitor: every observed tick must match the next expected cycle for that tick.
  always @(negedge clk) begin
    if (gravity_tick) begin
      if (gq.size() == 0) checkOutput("unexpected gravity_tick at cycle", cyc, -1);
      else checkOutput("gravity_tick cycle", cyc, gq.pop_front());
    end
    if (pipe_tick) begin
      if (pq.size() == 0) checkOutput("unexpected pipe_tick at cycle", cyc, -1);
      else checkOutput("pipe_tick cycle", cyc, pq.pop_front());
    end
    if (spawn_tick) begin
      if (sq.size() == 0) checkOutput("unexpected spawn_tick at cycle", cyc, -1);
      else checkOutput("spawn_tick cycle", cyc, sq.pop_front());
    end
  end

  // Directed scenario sequence.
  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset state", int'(state), 0);
    checkOutput("reset score", int'(score), 0);
    checkOutput("reset field_clear", int'(field_clear), 1);
    checkOutput("reset game_over", int'(game_over), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle holds", int'(state), 0);

    // Start pulse: READY for five cycles, then PLAY with field released.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("READY state", int'(state), 1);
      checkOutput("READY field_clear", int'(field_clear), 1);
      @(negedge clk);
    end
    checkOutput("PLAY entry", int'(state), 2);
    checkOutput("PLAY field_clear", int'(field_clear), 0);
    p0 = cyc;

    // 48 PLAY cycles: 12 gravity, 6 pipe and 2 spawn ticks.
    for (int k = 1; k <= 12; k++) gq.push_back(p0 + 4 * k);
    for (int k = 1; k <= 6; k++) pq.push_back(p0 + 8 * k);
    sq.push_back(p0 + 24);
    sq.push_back(p0 + 48);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 48);
    flushMissed();
    checkOutput("PLAY continues", int'(state), 2);
    b = cyc;

    // Six gate passes in a row: period 8 -> 6 -> 4 -> 4.
    // The shrinking period makes the pipe wrap early at b+5.
    for (int k = 1; k <= 6; k++) gq.push_back(b + 4 * k);
    for (int t = b + 5; t <= b + 21; t += 4) pq.push_back(t);
    sq.push_back(b + 13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6);
    gate_pass = 1'b0;
    checkOutput("score after 6 gates", int'(score), 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 18);
    flushMissed();
    c3 = cyc;

    // Pause for 20 cycles; ticks resume 21 cycles late with exact phase.
    gq.push_back(c3 + 25);
    gq.push_back(c3 + 29);
    pq.push_back(c3 + 22);
    pq.push_back(c3 + 26);
    sq.push_back(c3 + 22);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("PAUSE entry", int'(state), 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 18);
    checkOutput("PAUSE ignores inputs", int'(state), 3);
    checkOutput("PAUSE score frozen", int'(score), 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("PAUSE release", int'(state), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8);
    flushMissed();
    c4 = cyc;

    // Collision with gate_pass in the same cycle: OVER, no score, no pipe tick.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1);
    collision = 1'b0;
    gate_pass = 1'b0;
    checkOutput("OVER state", int'(state), 4);
    checkOutput("OVER score held", int'(score), 6);
    checkOutput("OVER game_over", int'(game_over), 1);
    checkOutput("OVER field_clear", int'(field_clear), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3);
    gate_pass = 1'b0;
    checkOutput("OVER ignores gate_pass", int'(score), 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    start = 1'b0;
    checkOutput("restart READY", int'(state), 1);
    checkOutput("restart score cleared", int'(score), 0);
    checkOutput("restart game_over", int'(game_over), 0);
    checkOutput("restart field_clear", int'(field_clear), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5);
    checkOutput("second PLAY entry", int'(state), 2);
    p1 = cyc;

    // Continuous gate passes up to saturation; period settles at the floor of 4.
`ifdef GOD_MODE_EN
    end_edge = p1 + 1002;
`else
    end_edge = p1 + 1001;
`endif
    for (int t = p1 + 4; t <= end_edge; t += 4) gq.push_back(t);
    for (int t = p1 + 5; t <= end_edge; t += 4) pq.push_back(t);
    for (int t = p1 + 13; t <= end_edge; t += 12) sq.push_back(t);
    gate_pass = 1'b1;
    for (int k = 1; k <= 1001; k++) begin
      @(negedge clk);
      if (k == 2) checkOutput("score ramp", int'(score), 2);
      if (k == 500) start = 1'b1;
      if (k == 501) start = 1'b0;
      if (k == 502) checkOutput("start ignored in PLAY", int'(state), 2);
      if (k == 998) checkOutput("score 998", int'(score), 998);
      if (k == 999) checkOutput("score 999", int'(score), 999);
      if (k == 1001) checkOutput("score saturates", int'(score), 999);
    end
    gate_pass = 1'b0;
`ifdef GOD_MODE_EN
    god_mode = 1'b1;
    collision = 1'b1;
    @(negedge clk);
    checkOutput("god_mode ignores collision", int'(state), 2);
    god_mode = 1'b0;
    @(negedge clk);
`else
    collision = 1'b1;
    @(negedge clk);
`endif
    collision = 1'b0;
    checkOutput("final OVER", int'(state), 4);
    checkOutput("final score held", int'(score), 999);
    repeat (3) @(negedge clk);
    flushMissed();
    checkOutput("scoreboard drained", gq.size() + pq.size() + sq.size(), 0);

    // Reset from OVER returns everything to reset values on the next edge.
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-game reset state", int'(state), 0);
    checkOutput("mid-game reset score", int'(score), 0);
    checkOutput("mid-game reset field_clear", int'(field_clear), 1);
    checkOutput("mid-game reset game_over", int'(game_over), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
